sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between a read-only fetch channel
// and a load/store channel. Requests are granted combinationally, and the
// response arrives one cycle later. Sustained throughput is one access per
// cycle.
// Optional macro ARB_ROUND_ROBIN_EN: when both channels request in the same
// cycle, alternate the grant against last_grant. Otherwise data always wins.
module sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = inst, 1 = data
  logic   store_q, store_d;            // kind of the pending data access
  logic   gnt_i, gnt_d;

  // Arbitration: a lone requester always wins. Nothing is granted during reset.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        gnt_d = ~last_grant_q;
        gnt_i =  last_grant_q;
`else
        gnt_d = 1'b1;
`endif
      end else begin
        gnt_i = inst_req;
        gnt_d = data_req;
      end
    end
  end

  // Next state, SRAM drive, and response outputs
  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    store_d      = store_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_rdata   = 32'h0;
    mem_en       = 1'b0;
    mem_we       = 4'b0000;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;

    if (gnt_i) begin
      inst_addr_ok = 1'b1;
      mem_en       = 1'b1;
      mem_addr     = inst_addr;
      state_d      = RESP_I;
      last_grant_d = 1'b0;
    end else if (gnt_d) begin
      data_addr_ok = 1'b1;
      mem_en       = 1'b1;
      mem_we       = data_wr ? data_wstrb : 4'b0000;
      mem_addr     = data_addr;
      mem_wdata    = data_wdata;
      state_d      = RESP_D;
      last_grant_d = 1'b1;
      store_d      = data_wr;
    end

    // Responses come from the access granted in the previous cycle.
    if (!rst) begin
      unique case (state_q)
        RESP_I: begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_rdata;
        end
        RESP_D: begin
          data_data_ok = 1'b1;
          data_rdata   = store_q ? 32'h0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // State registers. Reset drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      store_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      store_q      <= store_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors with hand-computed expectations.
// It covers reset, fetch, store, contention, back-to-back loads, and
// reset during an access.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_en;
  logic [3:0]  mem_we;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed handshake view: {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
  function automatic logic [31:0] hs();
    return {28'h0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic exp_d, prev_d;
    int   n_dgnt;

    // Reset with both requests present: nothing may come out.
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
    data_wstrb = 4'hF; inst_addr = 32'h44; data_addr = 32'h88;
    data_wdata = 32'h1234; mem_rdata = 32'hFFFF_FFFF;
    #2;
    chk("rst_hs",    hs(), 32'h0);
    chk("rst_mem",   {27'h0, mem_en, mem_we}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    #1;
    chk("idle_hs", hs(), 32'h0);

    // Store
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h100; data_wdata = 32'hAABB_CCDD;
    #1;
    chk("st_hs",    hs(), 32'h2);
    chk("st_mem",   {27'h0, mem_en, mem_we}, 32'h13);
    chk("st_addr",  mem_addr, 32'h100);
    chk("st_wdata", mem_wdata, 32'hAABB_CCDD);
    tick();
    data_req = 1'b0; data_wr = 1'b0; mem_rdata = 32'h1234_5678;
    #1;
    chk("st_rsp",   hs(), 32'h1);
    chk("st_rdata", data_rdata, 32'h0);
    chk("st_irdat", inst_rdata, 32'h0);

    // Single fetch (leaves last_grant = inst)
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #1;
    chk("if_hs",   hs(), 32'h8);
    chk("if_mem",  {27'h0, mem_en, mem_we}, 32'h10);
    chk("if_addr", mem_addr, 32'h1C00_0000);
    tick();
    inst_req = 1'b0; mem_rdata = 32'h0280_0C0C;
    #1;
    chk("if_rsp",   hs(), 32'h4);
    chk("if_rdata", inst_rdata, 32'h0280_0C0C);
    chk("if_drdat", data_rdata, 32'h0);
    chk("if_men",   {31'h0, mem_en}, 32'h0);

    // Both channels request for 4 cycles.
    n_dgnt = 0; prev_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      inst_req = 1'b1; inst_addr = 32'h200;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h300;
      mem_rdata = 32'hC0DE_0000 + k;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1;
      if (k > 0) begin
        chk("sim_rsp", {30'h0, inst_data_ok, data_data_ok}, prev_d ? 32'h1 : 32'h2);
        chk("sim_rdat", prev_d ? data_rdata : inst_rdata, 32'hC0DE_0000 + k);
      end
      chk("sim_gnt", {30'h0, inst_addr_ok, data_addr_ok}, exp_d ? 32'h1 : 32'h2);
      chk("sim_addr", mem_addr, exp_d ? 32'h300 : 32'h200);
      if (data_addr_ok) n_dgnt++;
      prev_d = exp_d;
    end
    tick();
    inst_req = 1'b0; data_req = 1'b0; mem_rdata = 32'hC0DE_0004;
    #1;
    chk("sim_last", {30'h0, inst_data_ok, data_data_ok}, prev_d ? 32'h1 : 32'h2);
`ifdef ARB_ROUND_ROBIN_EN
    chk("sim_ndgnt", n_dgnt, 32'd2);
`else
    chk("sim_ndgnt", n_dgnt, 32'd4);
`endif

    // Back-to-back loads to 0x0, 0x4, and 0x8
    for (int k = 0; k < 4; k++) begin
      tick();
      data_req = (k < 3); data_wr = 1'b0; data_addr = 32'(k * 4);
      mem_rdata = 32'hA000_0000 + k;
      #1;
      if (k < 3) begin
        chk("b2b_gnt",  {31'h0, data_addr_ok}, 32'h1);
        chk("b2b_addr", mem_addr, 32'(k * 4));
      end
      if (k > 0) begin
        chk("b2b_rsp",  {31'h0, data_data_ok}, 32'h1);
        chk("b2b_rdat", data_rdata, 32'hA000_0000 + k);
      end
    end

    // Reset while a load response is pending
    tick();
    data_req = 1'b0;
    #1;
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h40;
    #1;
    chk("rr_gnt", hs(), 32'h2);
    tick();
    data_req = 1'b0; rst = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    chk("rr_hs",    hs(), 32'h0);
    chk("rr_rdata", data_rdata, 32'h0);
    chk("rr_men",   {31'h0, mem_en}, 32'h0);
    tick();
    rst = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    #1;
    chk("rr_post", hs(), 32'h8);
    chk("rr_addr", mem_addr, 32'h1C00_0004);
    tick();
    inst_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("rr_irsp",  hs(), 32'h4);
    chk("rr_irdat", inst_rdata, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
